complex_matvec_scheduler: RTL and testbench

COMPLEX_MATVEC_SCHEDULER -- requirements
Module: complex_matvec_scheduler

---
 rtl/complex_matvec_scheduler_if.sv | 23 ++
 rtl/complex_matvec_scheduler.sv | 150 +++++++++++++++
 tb/tb_complex_matvec_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/complex_matvec_scheduler_if.sv
// Handshake bundle between the matrix-vector batch scheduler and its complex row units.
// The slave side is the scheduler, and the master side is the requester plus the unit array.
interface complex_matvec_scheduler_if #(
   parameter int unsigned no_of_units = 4
);
   logic                   start;
   logic [no_of_units-1:0] unit_ready;
   logic [no_of_units-1:0] unit_start;
   logic [7:0]             batch_idx;
   logic                   busy;
   logic                   finish;
   logic                   error;

   modport master (
      output start, unit_ready,
      input  unit_start, batch_idx, busy, finish, error
   );

   modport slave (
      input  start, unit_ready,
      output unit_start, batch_idx, busy, finish, error
   );
endinterface

// File: rtl/complex_matvec_scheduler.sv
// Sequences padded matrix rows through parallel complex row units in batches, then drains the decoder.
// The optional WAIT watchdog is enabled by the macro COMPLEX_MATVEC_TIMEOUT_EN.
module complex_matvec_scheduler #(
   parameter int unsigned no_of_eqn_per_cluster = 3,
   parameter int unsigned no_of_units           = 4,
   parameter int unsigned NI                    = 8,
   parameter int unsigned drain_cycles          = 10,
   parameter int unsigned timeout_cycles        = 64
) (
   input logic                        clk,
   input logic                        reset,
   complex_matvec_scheduler_if.slave  bus
);
   localparam int unsigned total    = no_of_eqn_per_cluster + (NI - no_of_eqn_per_cluster % NI);
   localparam int unsigned batches  = total / no_of_units;
   localparam int unsigned last_idx = batches - 1;
   localparam int unsigned dw       = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;

   if (batches < 1 || drain_cycles < 1 || timeout_cycles < 1) begin : g_bad_cfg
      $error("complex_matvec_scheduler: illegal parameter combination");
   end

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

   state_t                 state, state_n;
   logic [7:0]             idx, idx_n;
   logic [dw-1:0]          drain_cnt, drain_n;
   logic [no_of_units-1:0] unit_start_q;
   logic                   busy_q, finish_q;
   logic                   err;

`ifdef COMPLEX_MATVEC_TIMEOUT_EN
   localparam int unsigned ww = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   logic [ww-1:0] wd, wd_n;
   logic          set_err;
`endif

   // Next-state and counter decode
   always_comb begin
      state_n = state;
      idx_n   = idx;
      drain_n = drain_cnt;
`ifdef COMPLEX_MATVEC_TIMEOUT_EN
      wd_n    = wd;
      set_err = 1'b0;
`endif
      case (state)
         IDLE: begin
            idx_n   = '0;
            drain_n = '0;
            if (bus.start && !err) state_n = ISSUE;
         end
         ISSUE: begin
`ifdef COMPLEX_MATVEC_TIMEOUT_EN
            wd_n = '0;
`endif
            state_n = bus.start ? WAIT : IDLE;
            if (!bus.start) idx_n = '0;
         end
         WAIT: begin
            if (!bus.start) begin
               state_n = IDLE;
               idx_n   = '0;
            end else if (&bus.unit_ready) begin
               if (idx == 8'(last_idx)) begin
                  drain_n = dw'(drain_cycles - 1);
                  state_n = DRAIN;
               end else begin
                  idx_n   = 8'(idx + 8'd1);
                  state_n = ISSUE;
               end
`ifdef COMPLEX_MATVEC_TIMEOUT_EN
            end else if (wd == ww'(timeout_cycles - 1)) begin
               set_err = 1'b1;
               state_n = IDLE;
               idx_n   = '0;
            end else begin
               wd_n = ww'(wd + ww'(1));
`endif
            end
         end
         DRAIN: begin
            if (!bus.start) begin
               state_n = IDLE;
               idx_n   = '0;
               drain_n = '0;
            end else if (drain_cnt == '0) begin
               state_n = DONE;
            end else begin
               drain_n = dw'(drain_cnt - dw'(1));
            end
         end
         DONE: begin
            if (!bus.start) begin
               state_n = IDLE;
               idx_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
            drain_n = '0;
         end
      endcase
`ifdef COMPLEX_MATVEC_TIMEOUT_EN
      if (state_n == IDLE) wd_n = '0;
`endif
   end

   // State, counters and outputs registered from the next-state decode
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         drain_cnt    <= '0;
         unit_start_q <= '0;
         busy_q       <= 1'b0;
         finish_q     <= 1'b0;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         drain_cnt    <= drain_n;
         unit_start_q <= (state_n == ISSUE) ? '1 : '0;
         busy_q       <= (state_n == ISSUE) || (state_n == WAIT) || (state_n == DRAIN);
         finish_q     <= (state_n == DONE);
      end
   end

`ifdef COMPLEX_MATVEC_TIMEOUT_EN
   // Watchdog counter and sticky error; error holds IDLE until start is released
   always_ff @(posedge clk) begin
      if (reset) begin
         wd  <= '0;
         err <= 1'b0;
      end else begin
         wd <= wd_n;
         if (!bus.start)   err <= 1'b0;
         else if (set_err) err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   assign bus.unit_start = unit_start_q;
   assign bus.batch_idx  = idx;
   assign bus.busy       = busy_q;
   assign bus.finish     = finish_q;
   assign bus.error      = err;
endmodule

// File: tb/tb_complex_matvec_scheduler.sv
// Directed, table-driven checks of the batch scheduler at default parameters.
module tb_complex_matvec_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   complex_matvec_scheduler_if #(.no_of_units(4)) bus ();

   complex_matvec_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       s;
      logic [3:0] r;
      logic [3:0] us;
      int         idx;
      logic       busy;
      logic       fin;
   } vec_t;

   vec_t tbl[18];

   task automatic step(input logic s, input logic [3:0] r);
      bus.start      = s;
      bus.unit_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   initial begin
      int n;
      int pulses;

      // Constant all-ready run: ISSUE/WAIT alternate, then 10-edge drain and DONE hold
      tbl[0] = '{1'b1, 4'hF, 4'hF, 0, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 4'hF, 4'h0, 0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 4'hF, 4'hF, 1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 4'hF, 4'h0, 1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 4'hF, 4'h0, 1, 1'b1, 1'b0};
      for (int i = 5; i < 14; i++) tbl[i] = '{1'b1, 4'hF, 4'h0, 1, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 4'hF, 4'h0, 1, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 4'h0, 4'h0, 1, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 4'h0, 4'h0, 0, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 4'h0, 4'h0, 0, 1'b0, 1'b0};

      reset = 1'b1;
      step(1'b1, 4'hF);
      step(1'b1, 4'hF);
      chk("rst_unit_start", int'(bus.unit_start), 0);
      chk("rst_idx", int'(bus.batch_idx), 0);
      chk("rst_busy_fin_err", int'({bus.busy, bus.finish, bus.error}), 0);
      reset = 1'b0;
      step(1'b0, 4'h0);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].s, tbl[i].r);
         chk($sformatf("tbl%0d_unit_start", i), int'(bus.unit_start), int'(tbl[i].us));
         chk($sformatf("tbl%0d_idx", i), int'(bus.batch_idx), tbl[i].idx);
         chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
         chk($sformatf("tbl%0d_finish", i), int'(bus.finish), int'(tbl[i].fin));
      end

      // Partial ready must not advance; exactly one pulse per batch
      pulses = 0;
      step(1'b1, 4'h0);
      if (bus.unit_start != 0) pulses++;
      step(1'b1, 4'h7);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 4'h7);
         if (bus.unit_start != 0) pulses++;
         chk("partial_hold", int'({bus.busy, bus.batch_idx}), int'({1'b1, 8'd0}));
      end
      step(1'b1, 4'hF);
      if (bus.unit_start != 0) pulses++;
      chk("partial_adv_idx", int'(bus.batch_idx), 1);
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
      step(1'b1, 4'hF);
      n = 0;
      while (!bus.finish && n < 30) begin
         step(1'b1, 4'h0);
         if (bus.unit_start != 0) pulses++;
         n++;
      end
      chk("partial_finish_delay", n, 10);
      chk("partial_busy_at_finish", int'(bus.busy), 0);
      chk("partial_pulse_count", pulses, 2);
      step(1'b0, 4'h0);

      // Abort in DRAIN at count 5, then a fresh run
      step(1'b1, 4'hF);
      step(1'b1, 4'hF);
      step(1'b1, 4'hF);
      step(1'b1, 4'hF);
      step(1'b1, 4'hF);
      for (int i = 0; i < 4; i++) step(1'b1, 4'h0);
      step(1'b0, 4'h0);
      chk("abort_drain_out", int'({bus.busy, bus.finish, bus.batch_idx}), 0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 4'h0);
         if (bus.finish) n++;
      end
      chk("abort_no_finish", n, 0);
      step(1'b1, 4'h0);
      chk("restart_issue", int'({bus.unit_start, bus.batch_idx}), int'({4'hF, 8'd0}));

      // Reset during WAIT of batch 1 with start held
      step(1'b1, 4'h0);
      step(1'b1, 4'hF);
      step(1'b1, 4'h0);
      chk("pre_reset_idx", int'(bus.batch_idx), 1);
      reset = 1'b1;
      step(1'b1, 4'h0);
      chk("mid_reset_out", int'({bus.unit_start, bus.batch_idx, bus.busy, bus.finish, bus.error}), 0);
      reset = 1'b0;
      step(1'b1, 4'h0);
      chk("post_reset_issue", int'({bus.unit_start, bus.batch_idx, bus.busy}), int'({4'hF, 8'd0, 1'b1}));
      step(1'b0, 4'hF);
      chk("abort_issue", int'({bus.unit_start, bus.busy, bus.batch_idx}), 0);

      // Watchdog behaviour with units never ready
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
`ifdef COMPLEX_MATVEC_TIMEOUT_EN
      n = 0;
      while (!bus.error && n < 200) begin
         step(1'b1, 4'h0);
         n++;
      end
      chk("wd_expiry_cycles", n, 64);
      chk("wd_busy_low", int'(bus.busy), 0);
      step(1'b1, 4'h0);
      chk("wd_error_sticky", int'({bus.error, bus.busy}), int'({1'b1, 1'b0}));
      step(1'b0, 4'h0);
      chk("wd_error_clear", int'(bus.error), 0);
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 4'h0);
         if (bus.error || !bus.busy) n++;
      end
      chk("no_wd_wait_forever", n, 0);
      step(1'b0, 4'h0);
      chk("no_wd_abort", int'({bus.busy, bus.error}), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
